pwm_cfg_sched: RTL and testbench
================================

# pwm_cfg_sched

Configuration scheduler for the dead-time PWM generator. It turns debounced button rising-edge pulses into half-period (T) and step-size (scale) changes, and holds them in shadow registers. It commits them to the generator only at a PWM period boundary, so no period is ever emitted with a torn T. A watchdog forces the commit if the generator stops reporting period boundaries. The block sits between the button edge detector and the PWM counter/compare logic, all in the clk_400 domain.

## Interface
- T_W, 24, width of T (units of clk_400 cycles, 2.5 ns)
- T_RST, 400, reset value of T
- T_MIN, 64, lower clamp for T
- T_MAX, 2^24-1, upper clamp for T
- SCALE_MAX, 16, upper clamp for scale (power of two)
- DEAD_RST, 16, dead-time value driven on dead_active
- WDOG_CYC, 2^20, cycles PENDING may last before a forced commit

- clk_400  in  1  clock, 400 MHz
- rst  in  1  asynchronous, active-high reset
- btn_rise  in  4  one-cycle pulses: [0] T-=scale, [1] T+=scale, [2] scale<<=1, [3] scale>>=1
- period_end  in  1  one-cycle pulse from the generator in the cycle its counter wraps to 0
- t_active  out  T_W  committed T used by the generator
- dead_active  out  8  committed dead time, constant DEAD_RST
- scale  out  5  current step size, takes effect immediately (not shadowed)
- pending  out  1  shadow T differs from t_active
- cfg_update  out  1  one-cycle pulse in the cycle t_active changes
- forced  out  1  sticky flag: a watchdog commit has occurred

## Operation
- **Reset values:**
  - t_active = t_shadow = T_RST; dead_active = DEAD_RST; scale = 1.
  - pending = 0, cfg_update = 0, forced = 0; watchdog = 0; state IDLE.
- **Button priority:** if several btn_rise bits are high in one cycle, the lowest index wins and the others are dropped.
- **T arithmetic:**
  - Computed in T_W+1 bits, then clamped.
  - dec: t_shadow = max(t_shadow - scale, T_MIN).
  - inc: t_shadow = min(t_shadow + scale, T_MAX).
  - No wrap-around in either direction.
- **Scale arithmetic:**
  - scale<<1 saturates at SCALE_MAX.
  - scale>>1 saturates at 1.
  - scale is never 0.
- **States:**
  - IDLE: t_shadow == t_active.
    - A T-changing button that actually alters t_shadow moves the block to PENDING.
    - A clamped no-op stays in IDLE.
  - PENDING: waits for a period boundary or the watchdog.
    - period_end: t_active <= t_shadow; cfg_update = 1; next state IDLE.
    - Watchdog reaches WDOG_CYC-1: same commit, and forced <= 1.
- **Pending output:** pending = (state == PENDING).
- **Simultaneous button and period_end in PENDING:**
  - The commit uses the pre-button t_shadow.
  - t_shadow takes the new value.
  - If the new value differs from the committed value the block stays in PENDING, otherwise it goes to IDLE.
- **Return to the reset value:** a button press that returns t_shadow to t_active while PENDING moves the block to IDLE with no commit.
- **Watchdog:**
  - Counts while in PENDING.
  - Clears on entry to PENDING and on every commit.
- **Reset mid-operation:** asserting rst in PENDING discards the shadow value, and all outputs return to their reset values asynchronously.

## Timing
- btn_rise at edge n: t_shadow, scale and pending are updated after edge n (visible in cycle n+1).
- period_end high in cycle m while PENDING:
  - t_active is new from cycle m+1.
  - cfg_update is high for exactly cycle m+1.
- Commit latency: 1 cycle after period_end; worst case WDOG_CYC cycles after entering PENDING.
- The generator samples t_active only at its wrap. The cycle m+1 update therefore first affects the period that starts after the next wrap or after the current one, and is always consistent within a period.
- Fully synchronous to clk_400. Inputs are already debounced and pulsed; no synchronizers are needed.

## Structure
- Package pwm_pkg:
  - Constants: T_W, T_RST, T_MIN, DEAD_RST, SCALE_MAX.
  - Typedef: state enum {IDLE, PENDING}.
- One natural sub-module: pwm_cfg_alu, the combinational clamp-add/clamp-sub and saturating shift.
- The state register, shadow/active registers and watchdog stay in the top module.

## Test plan
- **Reset:** rst pulse → t_active = 400, scale = 1, dead_active = 16, pending = 0, forced = 0.
- **Increment and commit:** btn_rise = 4'b0010, then period_end 10 cycles later → pending = 1 for those cycles; t_active = 401 with cfg_update high exactly one cycle after period_end.
- **Scale saturation and T clamp:**
  - Five btn_rise[2] pulses → scale = 16.
  - Then btn_rise[0] repeatedly from T = 70 with T_MIN = 64 → t_shadow = 64, and further decrements leave it at 64 with no state change.
- **Simultaneous events:** PENDING with shadow 401, btn_rise[1] in the same cycle as period_end → t_active = 401, t_shadow = 402, still PENDING.
- **Multi-press priority:** btn_rise = 4'b0011 → only the decrement is applied (T = 399).
- **Watchdog and reset mid-operation:**
  - WDOG_CYC = 256: PENDING with no period_end → forced commit after 256 cycles, forced = 1.
  - rst asserted while PENDING → t_active = 400, forced = 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and state type for the PWM configuration scheduler.
package pwm_pkg;

   localparam int             T_W       = 24;
   localparam logic [T_W-1:0] T_RST     = 24'd400;
   localparam logic [T_W-1:0] T_MIN     = 24'd64;
   localparam logic [T_W-1:0] T_MAX     = {T_W{1'b1}};
   localparam logic [4:0]     SCALE_MAX = 5'd16;
   localparam logic [7:0]     DEAD_RST  = 8'd16;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

endpackage

// File: rtl/pwm_cfg_alu.sv
// Combinational button decode: clamped T add/sub and saturating scale shift.
module pwm_cfg_alu
   import pwm_pkg::*;
(
   input  logic [T_W-1:0] t_cur,
   input  logic [4:0]     scale_cur,
   input  logic [3:0]     btn,
   output logic [T_W-1:0] t_nxt,
   output logic [4:0]     scale_nxt
);

   // One guard bit above T_W catches both borrow and carry-out.
   function automatic logic [T_W-1:0] sat_sub(input logic [T_W-1:0] a, input logic [4:0] s);
      logic [T_W:0] d;
      d = {1'b0, a} - {{(T_W-4){1'b0}}, s};
      if (d[T_W] || (d[T_W-1:0] < T_MIN)) return T_MIN;
      return d[T_W-1:0];
   endfunction

   function automatic logic [T_W-1:0] sat_add(input logic [T_W-1:0] a, input logic [4:0] s);
      logic [T_W:0] d;
      d = {1'b0, a} + {{(T_W-4){1'b0}}, s};
      if (d > {1'b0, T_MAX}) return T_MAX;
      return d[T_W-1:0];
   endfunction

   function automatic logic [4:0] sat_shl(input logic [4:0] s);
      if (s >= SCALE_MAX) return SCALE_MAX;
      return {s[3:0], 1'b0};
   endfunction

   function automatic logic [4:0] sat_shr(input logic [4:0] s);
      if (s <= 5'd1) return 5'd1;
      return {1'b0, s[4:1]};
   endfunction

   // Lowest set bit wins; the rest of the pulse vector is dropped.
   always_comb begin
      t_nxt     = t_cur;
      scale_nxt = scale_cur;
      if (btn[0])      t_nxt     = sat_sub(t_cur, scale_cur);
      else if (btn[1]) t_nxt     = sat_add(t_cur, scale_cur);
      else if (btn[2]) scale_nxt = sat_shl(scale_cur);
      else if (btn[3]) scale_nxt = sat_shr(scale_cur);
   end

endmodule

// File: rtl/pwm_cfg_sched.sv
// Shadows T/scale updates from buttons and commits T to the PWM generator only
// at a period boundary, or on watchdog expiry if boundaries stop arriving.
module pwm_cfg_sched
   import pwm_pkg::*;
#(
   parameter int unsigned WDOG_CYC = 32'd1 << 20
) (
   input  logic           clk_400,
   input  logic           rst,
   input  logic [3:0]     btn_rise,
   input  logic           period_end,
   output logic [T_W-1:0] t_active,
   output logic [7:0]     dead_active,
   output logic [4:0]     scale,
   output logic           pending,
   output logic           cfg_update,
   output logic           forced
);

   localparam int             WDOG_W    = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

   state_t            state, state_nxt;
   logic [T_W-1:0]    t_shadow, t_alu, t_commit_val;
   logic [4:0]        scale_alu;
   logic [WDOG_W-1:0] wdog;
   logic              wdog_hit, commit;

   pwm_cfg_alu u_alu (
      .t_cur     (t_shadow),
      .scale_cur (scale),
      .btn       (btn_rise),
      .t_nxt     (t_alu),
      .scale_nxt (scale_alu)
   );

   assign dead_active = DEAD_RST;
   assign wdog_hit    = (wdog == WDOG_LAST);

   always_ff @(posedge clk_400 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Compare the post-button shadow with whatever t_active will hold next:
   // this covers entry, return-to-committed-value and button-during-commit.
   always_comb begin
      t_commit_val = commit ? t_shadow : t_active;
      state_nxt    = (t_alu != t_commit_val) ? PENDING : IDLE;
   end

   always_comb begin
      pending = (state == PENDING);
      commit  = pending && (period_end || wdog_hit);
   end

   always_ff @(posedge clk_400 or posedge rst) begin
      if (rst) begin
         t_shadow   <= T_RST;
         t_active   <= T_RST;
         scale      <= 5'd1;
         cfg_update <= 1'b0;
         forced     <= 1'b0;
         wdog       <= '0;
      end else begin
         t_shadow   <= t_alu;
         scale      <= scale_alu;
         cfg_update <= commit;
         if (commit) t_active <= t_shadow;
         if (pending && wdog_hit) forced <= 1'b1;
         if (commit || (state == IDLE && state_nxt == PENDING)) wdog <= '0;
         else if (pending)                                      wdog <= wdog + 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_cfg_sched.sv
// Directed bench for pwm_cfg_sched with a shortened watchdog.
`timescale 1ns/1ps
module tb_pwm_cfg_sched;
   import pwm_pkg::*;

   localparam int unsigned WDOG = 256;

   logic           clk_400 = 1'b0;
   logic           rst;
   logic [3:0]     btn_rise;
   logic           period_end;
   logic [T_W-1:0] t_active;
   logic [7:0]     dead_active;
   logic [4:0]     scale;
   logic           pending, cfg_update, forced;

   int total = 0;
   int bad   = 0;

   pwm_cfg_sched #(.WDOG_CYC(WDOG)) dut (
      .clk_400     (clk_400),
      .rst         (rst),
      .btn_rise    (btn_rise),
      .period_end  (period_end),
      .t_active    (t_active),
      .dead_active (dead_active),
      .scale       (scale),
      .pending     (pending),
      .cfg_update  (cfg_update),
      .forced      (forced)
   );

   always #5 clk_400 = ~clk_400;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_400);
      #1;
   endtask

   task automatic press(input logic [3:0] b);
      btn_rise = b;
      tick();
      btn_rise = 4'b0000;
   endtask

   task automatic pend_end(input logic [3:0] b);
      btn_rise   = b;
      period_end = 1'b1;
      tick();
      btn_rise   = 4'b0000;
      period_end = 1'b0;
   endtask

   initial begin
      int k;
      rst        = 1'b1;
      btn_rise   = 4'b0000;
      period_end = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      chk("rst_t_active", 32'(t_active), 400);
      chk("rst_scale", 32'(scale), 1);
      chk("rst_dead", 32'(dead_active), 16);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_forced", 32'(forced), 0);
      chk("rst_cfg_update", 32'(cfg_update), 0);

      press(4'b0011);
      chk("prio_shadow", 32'(dut.t_shadow), 399);
      chk("prio_pending", 32'(pending), 1);
      chk("prio_t_active", 32'(t_active), 400);

      press(4'b0010);
      chk("return_pending", 32'(pending), 0);
      chk("return_cfg_update", 32'(cfg_update), 0);
      chk("return_t_active", 32'(t_active), 400);

      press(4'b0010);
      chk("inc_shadow", 32'(dut.t_shadow), 401);
      for (int i = 0; i < 9; i++) begin
         chk("inc_pending_hold", 32'(pending), 1);
         chk("inc_t_active_hold", 32'(t_active), 400);
         tick();
      end

      pend_end(4'b0010);
      chk("simul_t_active", 32'(t_active), 401);
      chk("simul_shadow", 32'(dut.t_shadow), 402);
      chk("simul_pending", 32'(pending), 1);
      chk("simul_cfg_update", 32'(cfg_update), 1);
      tick();
      chk("simul_cfg_update_low", 32'(cfg_update), 0);

      pend_end(4'b0000);
      chk("commit_t_active", 32'(t_active), 402);
      chk("commit_cfg_update", 32'(cfg_update), 1);
      chk("commit_pending", 32'(pending), 0);
      tick();
      chk("commit_cfg_update_low", 32'(cfg_update), 0);

      press(4'b0100); chk("shl_1", 32'(scale), 2);
      press(4'b0100); chk("shl_2", 32'(scale), 4);
      press(4'b0100); chk("shl_3", 32'(scale), 8);
      press(4'b0100); chk("shl_4", 32'(scale), 16);
      press(4'b0100); chk("shl_sat", 32'(scale), 16);
      press(4'b1000); chk("shr_1", 32'(scale), 8);
      press(4'b1000); chk("shr_2", 32'(scale), 4);
      press(4'b1000); chk("shr_3", 32'(scale), 2);
      press(4'b1000); chk("shr_4", 32'(scale), 1);
      press(4'b1000); chk("shr_sat", 32'(scale), 1);
      chk("scale_no_pending", 32'(pending), 0);

      // 402 - 20*16 = 82, then 82 - 3*4 = 70
      repeat (4) press(4'b0100);
      repeat (20) press(4'b0001);
      chk("dec16_shadow", 32'(dut.t_shadow), 82);
      repeat (2) press(4'b1000);
      repeat (3) press(4'b0001);
      chk("dec4_shadow", 32'(dut.t_shadow), 70);
      pend_end(4'b0000);
      chk("t70_t_active", 32'(t_active), 70);
      chk("t70_pending", 32'(pending), 0);

      press(4'b1100);
      chk("prio_scale", 32'(scale), 8);
      press(4'b0100);
      chk("scale16", 32'(scale), 16);

      press(4'b0001);
      chk("clamp_shadow", 32'(dut.t_shadow), 64);
      chk("clamp_pending", 32'(pending), 1);
      pend_end(4'b0000);
      chk("clamp_t_active", 32'(t_active), 64);
      press(4'b0001);
      chk("clamp_noop_shadow", 32'(dut.t_shadow), 64);
      chk("clamp_noop_pending", 32'(pending), 0);
      chk("clamp_noop_cfg_update", 32'(cfg_update), 0);
      press(4'b0001);
      chk("clamp_noop2_shadow", 32'(dut.t_shadow), 64);
      chk("clamp_noop2_pending", 32'(pending), 0);

      press(4'b0010);
      chk("wdog_shadow", 32'(dut.t_shadow), 80);
      chk("wdog_forced_before", 32'(forced), 0);
      k = 0;
      while (k <= 400 && !cfg_update) begin
         tick();
         k++;
      end
      chk("wdog_latency", 32'(k), 256);
      chk("wdog_t_active", 32'(t_active), 80);
      chk("wdog_forced", 32'(forced), 1);
      chk("wdog_pending", 32'(pending), 0);

      press(4'b0010);
      chk("mid_pending", 32'(pending), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_t_active", 32'(t_active), 400);
      chk("mid_rst_forced", 32'(forced), 0);
      chk("mid_rst_pending", 32'(pending), 0);
      chk("mid_rst_scale", 32'(scale), 1);
      chk("mid_rst_shadow", 32'(dut.t_shadow), 400);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_pending", 32'(pending), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
